// File: rtl/fetch_queue_pkg.sv
// Shared fetch packet layout and queue sizing, used by fetch, decode and the pipeline registers.
package fetch_queue_pkg;

  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned PCP4_LSB  = 64;
  localparam int unsigned PKT_W     = 96;
  localparam int unsigned FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pcp4;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Assemble a packet from its fields using the shared offsets.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [31:0] pcp4,
                                                input logic [31:0] pc,
                                                input logic [31:0] instr);
    logic [PKT_W-1:0] p;
    p = '0;
    p[PCP4_LSB +: 32]  = pcp4;
    p[PC_LSB +: 32]    = pc;
    p[INSTR_LSB +: 32] = instr;
    return p;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = PKT_W,
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead FIFO decoupling fetch from the IF/ID register; occupancy tracked by count, flush empties it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned WIDTH = PKT_W,
  parameter  int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             hold,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(DEPTH - 1);

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] rdata;
  logic             pop;
  logic             accept;

  assign dout_valid  = (count != '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);
  assign dout        = dout_valid ? rdata : '0;

  // A full queue still accepts when the head leaves in the same cycle.
  assign pop    = !hold && dout_valid && !flush;
  assign accept = push && !flush && (!full || pop);

  fq_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      // Dropped push into a full, non-draining queue is remembered until reset.
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table with hand-written expected occupancy, packet scoreboard for dout.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush, push, hold;
  logic [PKT_W-1:0]  din;
  logic              full, almost_full, dout_valid, overflow;
  logic [PKT_W-1:0]  dout;
  logic [2:0]        count;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push        (push),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .hold        (hold),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic f;
    logic p;
    logic h;
    int   k;
    int   ec;
    logic eo;
  } vec_t;

  vec_t             tbl [29];
  logic [PKT_W-1:0] sb [$];
  int               n_checks = 0;
  int               n_pass   = 0;

  function automatic logic [PKT_W-1:0] pkt(input int k);
    return make_pkt(32'(4 * (k + 1)), 32'(4 * k), 32'h2000_0000 + 32'(k + 1) * 32'h0001_0001);
  endfunction

  function automatic vec_t v(input logic f, input logic p, input logic h,
                             input int k, input int ec, input logic eo);
    vec_t r;
    r.f = f; r.p = p; r.h = h; r.k = k; r.ec = ec; r.eo = eo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle; check head before the edge against the scoreboard, state after it.
  task automatic step(input int idx, input logic f, input logic p, input logic h,
                      input logic [PKT_W-1:0] d, input int ec, input logic eo);
    logic pop_m;
    flush = f; push = p; hold = h; din = d;
    #1;
    chk($sformatf("row%0d dout_valid", idx), PKT_W'(dout_valid), PKT_W'(sb.size() != 0));
    chk($sformatf("row%0d dout", idx), dout, (sb.size() != 0) ? sb[0] : '0);
    pop_m = (sb.size() != 0) && !h && !f;
    if (f) sb.delete();
    else begin
      if (pop_m) void'(sb.pop_front());
      if (p && sb.size() < FQ_DEPTH) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    chk($sformatf("row%0d count", idx), PKT_W'(count), PKT_W'(ec));
    chk($sformatf("row%0d overflow", idx), PKT_W'(overflow), PKT_W'(eo));
    chk($sformatf("row%0d full", idx), PKT_W'(full), PKT_W'(ec == 4));
    chk($sformatf("row%0d almost_full", idx), PKT_W'(almost_full), PKT_W'(ec >= 3));
  endtask

  initial begin
    //            f     p     h     pkt ec ovf
    tbl[0]  = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    tbl[1]  = v(1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    tbl[2]  = v(1'b0, 1'b1, 1'b1,  0, 1, 1'b0);
    tbl[3]  = v(1'b0, 1'b1, 1'b1,  1, 2, 1'b0);
    tbl[4]  = v(1'b0, 1'b0, 1'b0, -1, 1, 1'b0);
    tbl[5]  = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    tbl[6]  = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    tbl[7]  = v(1'b0, 1'b1, 1'b1,  2, 1, 1'b0);
    tbl[8]  = v(1'b0, 1'b1, 1'b1,  3, 2, 1'b0);
    tbl[9]  = v(1'b0, 1'b1, 1'b1,  4, 3, 1'b0);
    tbl[10] = v(1'b0, 1'b1, 1'b1,  5, 4, 1'b0);
    tbl[11] = v(1'b0, 1'b1, 1'b1,  6, 4, 1'b1);
    tbl[12] = v(1'b0, 1'b0, 1'b1, -1, 4, 1'b1);
    tbl[13] = v(1'b0, 1'b1, 1'b0,  7, 4, 1'b1);
    tbl[14] = v(1'b0, 1'b1, 1'b0,  8, 4, 1'b1);
    tbl[15] = v(1'b0, 1'b1, 1'b0,  9, 4, 1'b1);
    tbl[16] = v(1'b0, 1'b1, 1'b0, 10, 4, 1'b1);
    tbl[17] = v(1'b0, 1'b0, 1'b0, -1, 3, 1'b1);
    tbl[18] = v(1'b0, 1'b0, 1'b0, -1, 2, 1'b1);
    tbl[19] = v(1'b0, 1'b0, 1'b0, -1, 1, 1'b1);
    tbl[20] = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
    tbl[21] = v(1'b0, 1'b1, 1'b1, 11, 1, 1'b1);
    tbl[22] = v(1'b0, 1'b1, 1'b1, 12, 2, 1'b1);
    tbl[23] = v(1'b0, 1'b1, 1'b1, 13, 3, 1'b1);
    tbl[24] = v(1'b1, 1'b1, 1'b0, 14, 0, 1'b1);
    tbl[25] = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
    tbl[26] = v(1'b0, 1'b1, 1'b0, 15, 1, 1'b1);
    tbl[27] = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
    tbl[28] = v(1'b0, 1'b0, 1'b0, -1, 0, 1'b1);

    reset = 1'b1; flush = 1'b0; push = 1'b0; hold = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", PKT_W'(count), '0);
    chk("reset dout_valid", PKT_W'(dout_valid), '0);
    chk("reset dout", dout, '0);
    chk("reset full", PKT_W'(full), '0);
    chk("reset almost_full", PKT_W'(almost_full), '0);
    chk("reset overflow", PKT_W'(overflow), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++)
      step(i, tbl[i].f, tbl[i].p, tbl[i].h, (tbl[i].k >= 0) ? pkt(tbl[i].k) : '0,
           tbl[i].ec, tbl[i].eo);

    // Reset mid-run with three entries must empty the queue before the next edge.
    for (int i = 0; i < 3; i++)
      step(100 + i, 1'b0, 1'b1, 1'b1, pkt(20 + i), i + 1, 1'b1);
    push = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("async reset count", PKT_W'(count), '0);
    chk("async reset dout_valid", PKT_W'(dout_valid), '0);
    chk("async reset dout", dout, '0);
    chk("async reset overflow", PKT_W'(overflow), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(200, 1'b0, 1'b1, 1'b0, pkt(30), 1, 1'b0);
    step(201, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
